cache_controller_mp: RTL

- Multi-requester successor to the single-port cache controller.
- Round-robin arbitrates NUM_CPU read/write request channels onto one tag/data array and one ACE master interface.
- Services snoops with priority over CPU requests; bounds every ACE handshake with a timeout.
- Sits between the CPU request ports, the tag array (hit/miss/line_state) and the ACE interconnect adapter.

---
 rtl/cache_ctrl_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/cache_controller_mp.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the multi-port cache controller: MOESI-style line state
// encodings, CPU op codes, controller FSM states and line-state helpers.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_I = 3'b000,
    ST_M = 3'b001,
    ST_E = 3'b010,
    ST_O = 3'b011,
    ST_S = 3'b100
  } line_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_LOOKUP,
    FSM_WB,
    FSM_FILL,
    FSM_UPGRADE,
    FSM_UPDATE,
    FSM_SNOOP,
    FSM_RESP
  } fsm_e;

  function automatic logic is_dirty(input logic [2:0] ls);
    return (ls == ST_M) || (ls == ST_O);
  endfunction

  // A sharing snoop demotes unique lines to their shared flavour; O/S/I stay put.
  function automatic logic [2:0] snoop_next(input logic [2:0] ls, input logic inv);
    logic [2:0] ns;
    ns = ls;
    if (inv)              ns = ST_I;
    else if (ls == ST_M)  ns = ST_O;
    else if (ls == ST_E)  ns = ST_S;
    return ns;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid channel at or after the
// pointer; the pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter  int NUM_CPU = 2,
  localparam int ID_W    = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CPU-1:0] valid,
  input  logic               accept,
  output logic [NUM_CPU-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  assign any_valid = |valid;

  // Scan offsets from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    int j;
    j = 0;
    grant_idx = ptr_q;
    for (int k = NUM_CPU - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_CPU) j = j - NUM_CPU;
      if (valid[j]) grant_idx = ID_W'(j);
    end
  end

  for (genvar gi = 0; gi < NUM_CPU; gi++) begin : g_grant
    assign grant[gi] = any_valid && (int'(grant_idx) == gi);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && any_valid)
      ptr_d = (int'(grant_idx) == NUM_CPU - 1) ? '0 : ID_W'(int'(grant_idx) + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cache_controller_mp.sv
// Multi-requester cache controller: arbitrates CPU channels onto one tag/data
// array and one ACE master port, gives snoops priority, and times out ACE waits.
module cache_controller_mp
  import cache_ctrl_pkg::*;
#(
  parameter  int NUM_CPU     = 2,
  parameter  int TIMEOUT_CYC = 16,
  localparam int ID_W        = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CPU-1:0] cpu_req_valid,
  input  logic [NUM_CPU-1:0] cpu_req_op,
  output logic [NUM_CPU-1:0] cpu_req_ready,
  input  logic               cache_hit,
  input  logic               cache_miss,
  input  logic [2:0]         line_state,
  input  logic               ace_ready,
  input  logic               ace_shared,
  input  logic               snoop_valid,
  input  logic               snoop_inv,
  output logic               snoop_ready,
  output logic               snoop_dirty,
  output logic               read_req,
  output logic               write_req,
  output logic               invalid_req,
  output logic               write_from_cpu,
  output logic               write_from_interconnect,
  output logic [2:0]         new_state,
  output logic               state_sel,
  output logic               cache_complete,
  output logic [ID_W-1:0]    resp_id,
  output logic               resp_err,
  output logic               cache_ready
);

  fsm_e            state_q, state_d;
  logic            op_q, op_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [NUM_CPU-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_valid;
  logic               arb_accept;
  logic               ace_wait;
  logic               expire;

  assign arb_accept = (state_q == FSM_IDLE) && !snoop_valid;
  assign ace_wait   = (state_q == FSM_WB) || (state_q == FSM_FILL) || (state_q == FSM_UPGRADE);
  // Expiry only when ace_ready is also low, so a last-cycle handshake still wins.
  assign expire     = (TIMEOUT_CYC != 0) && !ace_ready && (cnt_q == 16'(TIMEOUT_CYC - 1));

  rr_arbiter #(.NUM_CPU(NUM_CPU)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .valid     (cpu_req_valid),
    .accept    (arb_accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cpu_req_ready           = '0;
    snoop_ready             = 1'b0;
    snoop_dirty             = 1'b0;
    read_req                = 1'b0;
    write_req               = 1'b0;
    invalid_req             = 1'b0;
    write_from_cpu          = 1'b0;
    write_from_interconnect = 1'b0;
    new_state               = ST_I;
    state_sel               = 1'b0;
    cache_complete          = 1'b0;
    resp_id                 = '0;
    resp_err                = 1'b0;
    cache_ready             = 1'b0;
    case (state_q)
      FSM_IDLE: begin
        cache_ready = 1'b1;
        if (snoop_valid) begin
          state_d = FSM_SNOOP;
        end else if (any_valid) begin
          cpu_req_ready = grant;
          op_d    = |(cpu_req_op & grant);
          id_d    = grant_idx;
          err_d   = 1'b0;
          state_d = FSM_LOOKUP;
        end
      end
      FSM_LOOKUP: begin
        cnt_d = '0;
        if (cache_hit) begin
          if (op_q == OP_READ)                         state_d = FSM_RESP;
          else if (line_state == ST_M || line_state == ST_E) state_d = FSM_UPDATE;
          else                                         state_d = FSM_UPGRADE;
        end else if (cache_miss) begin
          state_d = is_dirty(line_state) ? FSM_WB : FSM_FILL;
        end
      end
      FSM_WB: begin
        write_req = 1'b1;
        if (ace_ready) begin
          state_sel = 1'b1;
          new_state = ST_I;
          cnt_d     = '0;
          state_d   = FSM_FILL;
        end
      end
      FSM_FILL: begin
        read_req = 1'b1;
        if (ace_ready) begin
          write_from_interconnect = 1'b1;
          state_sel = 1'b1;
          new_state = ace_shared ? ST_S : ST_E;
          state_d   = (op_q == OP_READ) ? FSM_RESP : FSM_UPDATE;
        end
      end
      FSM_UPGRADE: begin
        invalid_req = 1'b1;
        if (ace_ready) state_d = FSM_UPDATE;
      end
      FSM_UPDATE: begin
        write_from_cpu = 1'b1;
        state_sel      = 1'b1;
        new_state      = ST_M;
        state_d        = FSM_RESP;
      end
      FSM_SNOOP: begin
        snoop_ready = 1'b1;
        snoop_dirty = is_dirty(line_state);
        state_sel   = 1'b1;
        new_state   = snoop_next(line_state, snoop_inv);
        state_d     = FSM_IDLE;
      end
      FSM_RESP: begin
        cache_complete = 1'b1;
        resp_id        = id_q;
        resp_err       = err_q;
        state_d        = FSM_IDLE;
      end
      default: state_d = FSM_IDLE;
    endcase
    if (ace_wait && !ace_ready) begin
      if (expire) begin
        err_d   = 1'b1;
        state_d = FSM_RESP;
      end else if (TIMEOUT_CYC != 0) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FSM_IDLE;
      op_q    <= 1'b0;
      id_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
